// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, mux selects,
// ALU operation classes and the controller state enumeration.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_AEX    = 4'd9,
        S_AWB    = 4'd10,
        S_BR     = 4'd11,
        S_JMP    = 4'd12,
        S_HALT   = 4'd13
    } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath (slave).
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 16);

    logic             run;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;

    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             branch_ne;
    logic             retire;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               branch_ne, retire, halted, instr_count
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               branch_ne, retire, halted, instr_count
    );

endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: sequences fetch/decode/execute/memory/writeback,
// waits on the memory ready handshake and counts retired instructions.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter bit HALT_ILL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] count_r;
    logic             pc_write_s;
    logic             pc_write_cond_s;
    logic             branch_ne_s;
    logic             retire_s;

    // State and retired-instruction counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (retire_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Next-state decode and datapath control; IDLE/HALT/reset leave everything low.
    always_comb begin
        state_s         = state_r;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        branch_ne_s     = 1'b0;
        retire_s        = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_B;
        bus.alu_op      = ALU_ADD;
        bus.pc_source   = PCSRC_ALU;
        bus.halted      = 1'b0;

        case (state_r)
            S_IDLE: state_s = S_FETCH;
            S_FETCH: begin
                if (bus.run) begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    // IR load and PC+4 happen only in the cycle memory delivers the word.
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        pc_write_s   = 1'b1;
                        state_s      = S_DECODE;
                    end else begin
                        state_s = S_FETCH;
                    end
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SL2;
                case (bus.opcode)
                    OP_LW, OP_SW:    state_s = S_MEMADR;
                    OP_R:            state_s = S_REX;
                    OP_ADDI:         state_s = S_AEX;
                    OP_BEQ, OP_BNE:  state_s = S_BR;
                    OP_J:            state_s = S_JMP;
                    default: begin
                        if (HALT_ILL) begin
                            state_s = S_HALT;
                        end else begin
                            retire_s = 1'b1;
                            state_s  = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                if (bus.opcode == OP_SW) begin
                    state_s = S_MEMWR;
                end else begin
                    state_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_s = S_MEMWB;
                end else begin
                    state_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire_s       = 1'b1;
                state_s        = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    retire_s = 1'b1;
                    state_s  = S_FETCH;
                end else begin
                    state_s = S_MEMWR;
                end
            end
            S_REX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
                state_s       = S_RWB;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire_s      = 1'b1;
                state_s       = S_FETCH;
            end
            S_AEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_s       = S_AWB;
            end
            S_AWB: begin
                bus.reg_write = 1'b1;
                retire_s      = 1'b1;
                state_s       = S_FETCH;
            end
            S_BR: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_op      = ALU_SUB;
                bus.pc_source   = PCSRC_ALUOUT;
                pc_write_cond_s = 1'b1;
                branch_ne_s     = (bus.opcode == OP_BNE);
                retire_s        = 1'b1;
                state_s         = S_FETCH;
            end
            S_JMP: begin
                bus.pc_source = PCSRC_JUMP;
                pc_write_s    = 1'b1;
                retire_s      = 1'b1;
                state_s       = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                state_s    = S_HALT;
            end
            default: state_s = S_IDLE;
        endcase

        bus.pc_en     = pc_write_s | (pc_write_cond_s & (bus.zero ^ branch_ne_s));
        bus.branch_ne = branch_ne_s;
        bus.retire    = retire_s;
    end

    assign bus.instr_count = count_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: each instruction class is expanded
// into its expected per-cycle control pattern and compared every cycle.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_ctrl #(.CNT_W(CNT_W), .HALT_ILL(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       branch_ne;
        logic       retire;
        logic       halted;
    } ctrl_t;

    ctrl_t            exp_c;
    ctrl_t            act_c;
    logic             chk_en = 1'b0;
    logic [CNT_W-1:0] model_count = '0;
    int               n_pass = 0;
    int               n_total = 0;
    int               cyc_n = 0;

    assign act_c = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                    bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.pc_source, bus.branch_ne,
                    bus.retire, bus.halted};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the expected pattern and the retire-count model.
    always @(negedge clk) begin
        if (reset) model_count = '0;
        if (chk_en) begin
            chk("ctrl_outputs", 32'(act_c), 32'(exp_c));
            chk("instr_count", 32'(bus.instr_count), 32'(model_count));
            if (!reset && exp_c.retire) model_count = model_count + 4'd1;
        end
    end

    task automatic cyc(input logic r, input logic [5:0] op, input logic z,
                       input logic rdy, input ctrl_t e);
        bus.run       = r;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        exp_c         = e;
        chk_en        = 1'b1;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t fetch_exp(input logic done);
        ctrl_t e;
        e = '0;
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        if (done) begin
            e.ir_write = 1'b1;
            e.pc_en    = 1'b1;
        end
        return e;
    endfunction

    function automatic ctrl_t decode_exp();
        ctrl_t e;
        e = '0;
        e.alu_src_b = 2'b11;
        return e;
    endfunction

    // One whole instruction: fetch (with fwait stall cycles), decode, then the class-specific steps.
    task automatic do_instr(input logic [5:0] op, input logic z, input int fwait, input int mwait);
        ctrl_t e;
        for (int i = 0; i < fwait; i++) cyc(1'b1, op, z, 1'b0, fetch_exp(1'b0));
        cyc(1'b1, op, z, 1'b1, fetch_exp(1'b1));
        cyc(1'b1, op, z, 1'b1, decode_exp());
        case (op)
            OP_LW, OP_SW: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                cyc(1'b1, op, z, 1'b1, e);
                e = '0; e.iord = 1'b1;
                if (op == OP_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                for (int i = 0; i < mwait; i++) cyc(1'b1, op, z, 1'b0, e);
                if (op == OP_SW) e.retire = 1'b1;
                cyc(1'b1, op, z, 1'b1, e);
                if (op == OP_LW) begin
                    e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1;
                    cyc(1'b1, op, z, 1'b1, e);
                end
            end
            OP_R: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
                cyc(1'b1, op, z, 1'b1, e);
                e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1;
                cyc(1'b1, op, z, 1'b1, e);
            end
            OP_ADDI: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                cyc(1'b1, op, z, 1'b1, e);
                e = '0; e.reg_write = 1'b1; e.retire = 1'b1;
                cyc(1'b1, op, z, 1'b1, e);
            end
            OP_BEQ, OP_BNE: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
                e.branch_ne = (op == OP_BNE); e.retire = 1'b1;
                e.pc_en = z ^ (op == OP_BNE);
                cyc(1'b1, op, z, 1'b1, e);
            end
            OP_J: begin
                e = '0; e.pc_en = 1'b1; e.pc_source = 2'b10; e.retire = 1'b1;
                cyc(1'b1, op, z, 1'b1, e);
            end
            default: begin
                e = '0; e.halted = 1'b1;
                for (int i = 0; i < 6; i++) cyc(i[0], OP_R, i[1], i[0], e);
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        ctrl_t e;
        reset = 1'b1;
        bus.run = 1'b0; bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        exp_c = '0;
        @(posedge clk); #1;
        cyc(1'b1, OP_R, 1'b0, 1'b1, '0);
        cyc(1'b1, OP_R, 1'b0, 1'b1, '0);
        reset = 1'b0;
        cyc(1'b1, OP_R, 1'b0, 1'b1, '0);

        do_instr(OP_R, 1'b0, 0, 0);
        chk("count_after_r", 32'(bus.instr_count), 32'd1);
        c0 = cyc_n;
        do_instr(OP_LW, 1'b0, 0, 2);
        chk("lw_cycles", 32'(cyc_n - c0), 32'd7);
        c0 = cyc_n;
        do_instr(OP_SW, 1'b0, 1, 1);
        chk("sw_cycles", 32'(cyc_n - c0), 32'd6);
        do_instr(OP_BEQ, 1'b1, 0, 0);
        do_instr(OP_BEQ, 1'b0, 0, 0);
        do_instr(OP_BNE, 1'b0, 0, 0);
        do_instr(OP_BNE, 1'b1, 0, 0);
        do_instr(OP_J, 1'b0, 0, 0);
        do_instr(OP_ADDI, 1'b1, 0, 0);

        for (int i = 0; i < 5; i++) cyc(1'b0, OP_R, 1'b0, 1'b1, '0);
        do_instr(OP_R, 1'b0, 0, 0);
        chk("count_before_wrap", 32'(bus.instr_count), 32'd10);
        for (int i = 0; i < 6; i++) do_instr(OP_J, 1'b0, 0, 0);
        chk("count_wrapped", 32'(bus.instr_count), 32'd0);
        do_instr(OP_R, 1'b0, 0, 0);

        // Store stalled in its memory write, then reset lands mid-cycle.
        cyc(1'b1, OP_SW, 1'b0, 1'b1, fetch_exp(1'b1));
        cyc(1'b1, OP_SW, 1'b0, 1'b1, decode_exp());
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        cyc(1'b1, OP_SW, 1'b0, 1'b1, e);
        e = '0; e.mem_write = 1'b1; e.iord = 1'b1;
        cyc(1'b1, OP_SW, 1'b0, 1'b0, e);
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        exp_c = '0;
        #1;
        chk("reset_async_outputs", 32'(act_c), 32'd0);
        chk("reset_async_count", 32'(bus.instr_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b1, OP_SW, 1'b0, 1'b1, '0);
        do_instr(OP_R, 1'b0, 0, 0);

        do_instr(6'b111111, 1'b0, 0, 0);
        chk("halt_count_held", 32'(bus.instr_count), 32'd1);
        chk("halt_flag", 32'(bus.halted), 32'd1);
        reset = 1'b1;
        cyc(1'b1, OP_R, 1'b0, 1'b1, '0);
        reset = 1'b0;
        cyc(1'b1, OP_R, 1'b0, 1'b0, '0);
        cyc(1'b1, OP_R, 1'b0, 1'b0, fetch_exp(1'b0));
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
